// File: rtl/adder_pkg.sv
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared constants, FSM encodings and nibble-count helper for
//                the nibble-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/RCA_4bit.sv
// ============================================================================
//  Module      : RCA_4bit
//  Description : Nibble-wide ripple-carry adder used as the serial datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module RCA_4bit
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
);

    logic w_c;

    always_comb begin
        w_c   = i_cin;
        o_sum = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
            w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_c;
    end

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
//  Module      : nibble_serial_adder
//  Description : WIDTH-bit adder evaluated one nibble per clock, LSB first,
//                with valid/ready handshakes on operands and result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                NIB      = nib_count(WIDTH);
    localparam int                IDX_W    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NIB - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;
    logic [IDX_W-1:0]    r_idx;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_nsum;
    logic                w_nco;
    logic                w_accept;
    logic                w_last;

    assign w_a_nib  = r_a[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_b_nib  = r_b[r_idx*NIBBLE_W +: NIBBLE_W];
    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_state == ST_ADD) && (r_idx == LAST_IDX);

    RCA_4bit u_rca (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_cin  (r_carry),
        .o_sum  (w_nsum),
        .o_cout (w_nco)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next_state = ST_ADD;
            ST_ADD:  if (w_last)    w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default:                w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    // Sum is written in place nibble by nibble, so the previous result stays
    // visible until the next operation overwrites it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
        end else if (r_state == ST_ADD) begin
            r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_nsum;
            r_carry <= w_nco;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_cout <= w_nco;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_nsum[NIBBLE_W-1] != r_a[WIDTH-1]);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
//  Module      : tb_nibble_serial_adder
//  Description : Scoreboard bench for nibble_serial_adder (WIDTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   rdy_mode = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        exp_t        e;
        int unsigned u;
        int          s;
        u = 32'(x) + 32'(y) + 32'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        e.sum  = u[WIDTH-1:0];
        e.cout = u[WIDTH];
        e.ovf  = (s > 32767) || (s < -32768);
        e.acc  = 0;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                        input bit dir, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_t e;
        int   w;
        in_valid = 1'b1;
        a = x; b = y; cin = c;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
            in_valid = 1'b0;
            return;
        end
        e = model(x, y, c);
        if (dir) begin
            e.sum = es; e.cout = ec; e.ovf = eo;
        end
        e.acc = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    endtask

    task automatic drain(input int limit);
        int w;
        w = 0;
        while ((sbq.size() != 0 || out_valid) && w < limit) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: owns out_ready and pops the scoreboard on each handshake.
    initial begin : monitor
        exp_t e;
        logic prev_ov;
        prev_ov   = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            if (out_valid && !prev_ov && sbq.size() != 0)
                chk("latency", 32'(cyc - sbq[0].acc), 32'(NIB));
            prev_ov = out_valid;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_result: got sum 0x%0h expected no result", sum);
                end else begin
                    e = sbq.pop_front();
                    chk("sum",  32'(sum),  32'(e.sum));
                    chk("cout", 32'(cout), 32'(e.cout));
                    chk("ovf",  32'(ovf),  32'(e.ovf));
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_cmp++; n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : stim
        int   w;
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sum",       32'(sum),       32'd0);
        chk("rst_cout",      32'(cout),      32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        send(16'h1234, 16'h4321, 1'b0, 1, 16'h5555, 1'b0, 1'b0);
        drain(50);
        send(16'hFFFF, 16'h0000, 1'b1, 1, 16'h0000, 1'b1, 1'b0);
        drain(50);
        send(16'h7FFF, 16'h0001, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
        drain(50);
        send(16'h8000, 16'h8000, 1'b0, 1, 16'h0000, 1'b1, 1'b1);
        drain(50);

        // Consumer stall in DONE with a competing operand offer
        rdy_mode = 2;
        send(16'hA5A5, 16'h1234, 1'b1, 1, 16'hB7DA, 1'b0, 1'b0);
        w = 0;
        while (!out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("stall_reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_sum",       32'(sum),       32'hB7DA);
            chk("stall_cout",      32'(cout),      32'd0);
            chk("stall_in_ready",  32'(in_ready),  32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        drain(50);
        seen = 1'b0;
        repeat (NIB + 3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("stall_input_ignored", 32'(seen), 32'd0);
        chk("idle_in_ready",       32'(in_ready), 32'd1);

        // Reset in the second ADD cycle aborts the operation
        send(16'h1111, 16'h2222, 1'b0, 0, '0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        void'(sbq.pop_back());
        #1;
        chk("abort_sum",       32'(sum),       32'd0);
        chk("abort_cout",      32'(cout),      32'd0);
        chk("abort_ovf",       32'(ovf),       32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_pulse", 32'(seen), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'h0009, 16'h000E, 1'b1, 1, 16'h0018, 1'b0, 1'b0);
        drain(50);

        // Random back-to-back traffic with consumer stalls
        rdy_mode = 1;
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 0, '0, 1'b0, 1'b0);
        end
        drain(500);
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
